uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Host-side bus initiator: decodes command frames from a UART byte stream (fiber link) and issues single-word reads/writes on the softcore native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Returns the read data or an acknowledgement as bytes.
- Sits between the simpleuart byte interface and the bus, in parallel with the core, for debug/peek/poke of RAM and peripherals.
- The core-vs-master arbiter is outside this block.

Parameters:
- BUS_TIMEOUT, 1024, max clk cycles mem_valid_o is held awaiting mem_ready_i before abort.
- FRAME_TIMEOUT, 800000, max idle clk cycles between bytes of one frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid; no back-pressure
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts when tx_valid & tx_ready
- mem_valid_o  output  1  bus request
- mem_ready_i  input  1  bus completion (OR of all responders)
- mem_addr_o  output  32  bus address
- mem_wdata_o  output  32  write data
- mem_wstrb_o  output  4  byte strobes; 0 = read
- mem_rdata_i  input  32  read data, valid when mem_ready_i high
- busy  output  1  high in any state except IDLE
- rx_overrun  output  1  one-cycle pulse when rx_valid arrives in BUS or RESP (byte dropped)

Behaviour:
- Reset (resetn low at posedge): state IDLE. All outputs 0: tx_valid, tx_data, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, busy, rx_overrun. Counters cleared. Reset mid-transaction drops mem_valid_o and tx_valid the next cycle with no response.
- Frame formats, all multi-byte fields MSB first:
  - Read: 0x52 ('R'), addr[4].
  - Write: 0x57 ('W'), addr[4], data[4], strb[1] (low nibble used; high nibble ignored).
- States: IDLE -> ADDR (4 bytes) -> [write: DATA (4 bytes) -> STRB (1 byte)] -> BUS -> RESP -> IDLE.
- IDLE:
  - 0x52 or 0x57 sets op and enters ADDR.
  - Any other byte is ignored: stay in IDLE, no response.
- ADDR/DATA/STRB:
  - Shift bytes into the addr/wdata/strb registers; a byte counter selects the field.
  - Inter-byte counter resets on each rx_valid.
  - Counter reaching FRAME_TIMEOUT returns to IDLE, discards the frame, no response.
- BUS entry: the cycle after the last frame byte, mem_valid_o=1.
  - mem_addr_o = addr with addr[1:0] forced to 0.
  - mem_wstrb_o = strb for a write, 4'h0 for a read.
  - mem_wdata_o = data.
  - All held stable until completion.
- BUS completion:
  - Ready sampled high: capture mem_rdata_i, deassert mem_valid_o the next cycle, go to RESP, tx queue = OK.
  - Timeout: if BUS_TIMEOUT cycles elapse with mem_ready_i low, deassert mem_valid_o, go to RESP, tx queue = T.
- mem_ready_i high when mem_valid_o is low is ignored.
- Simultaneous ready and timeout expiry: ready wins.
- RESP transmit:
  - Read OK: 4 bytes rdata[31:24], [23:16], [15:8], [7:0].
  - Write OK: single 0x4B ('K').
  - Timeout: single 0x54 ('T').
  - Each byte: tx_valid=1 with tx_data stable until tx_ready; next byte presented the cycle after acceptance (tx_valid may stay high across bytes).
  - After the last accepted byte, tx_valid=0 and return to IDLE.
- rx_valid in BUS/RESP: byte dropped, rx_overrun pulses one cycle; state unaffected.
- Throughput and latency: one transaction in flight. Minimum read latency from last rx byte to mem_valid_o: 1 cycle.

Test Plan:
- Read: rx 52 00 00 00 10, responder returns rdata=0xDEADBEEF after 3 wait cycles -> mem_valid_o held 4 cycles, addr=0x00000010, wstrb=0; tx 0xDE,0xAD,0xBE,0xEF.
- Write: rx 57 10 00 00 00 12 34 56 78 03, immediate ready -> addr=0x10000000, wdata=0x12345678, wstrb=4'b0011; tx single 0x4B.
- Bus timeout: BUS_TIMEOUT=16, read to unmapped 0x20000000 with no ready -> mem_valid_o high exactly 16 cycles, then tx 0x54; return to IDLE, busy=0.
- Frame timeout/garbage: rx 0x41, then 52 00 00 followed by FRAME_TIMEOUT idle cycles -> no bus cycle and no tx; a following valid read frame completes normally.
- Back-pressure/overrun: tx_ready low 10 cycles during read response and an rx byte injected in RESP -> tx_data stable while stalled, bytes in order, rx_overrun pulses once.
- Reset mid-BUS: resetn low while mem_valid_o=1 -> next cycle mem_valid_o=0, tx_valid=0, busy=0; a subsequent frame works.

Source files
------------

// File: rtl/uart_bus_master_if.sv
// Native memory bus between the UART debug master and the responders.
// The master drives the request; the slave side returns ready and read data.
`timescale 1ns/1ps
interface uart_bus_master_if;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes 'R'/'W' command frames from the byte stream,
// issues one bus access, and streams back read data or a 'K'/'T' status byte.
`timescale 1ns/1ps
module uart_bus_master #(
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 800000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  uart_bus_master_if.master        mem,
  output logic                     busy,
  output logic                     rx_overrun
);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_TO = 8'h54;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_STRB, S_BUS, S_RESP} state_t;

  state_t          state;
  logic            op_wr;
  logic [1:0]      byte_cnt;
  logic [FW-1:0]   frame_cnt;
  logic [BW-1:0]   bus_cnt;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [23:0]     resp_sh;
  logic [1:0]      resp_left;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      op_wr           <= 1'b0;
      byte_cnt        <= '0;
      frame_cnt       <= '0;
      bus_cnt         <= '0;
      addr            <= '0;
      wdata           <= '0;
      resp_sh         <= '0;
      resp_left       <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      rx_overrun      <= 1'b0;
      mem.mem_valid_o <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      mem.mem_wstrb_o <= '0;
    end else begin
      rx_overrun <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_R || rx_data == CMD_W)) begin
            op_wr     <= (rx_data == CMD_W);
            byte_cnt  <= '0;
            frame_cnt <= '0;
            state     <= S_ADDR;
          end
        end

        S_ADDR, S_DATA, S_STRB: begin
          if (rx_valid) begin
            frame_cnt <= '0;
            byte_cnt  <= byte_cnt + 2'd1;
            if (state == S_ADDR) begin
              addr <= {addr[23:0], rx_data};
              if (byte_cnt == 2'd3) begin
                if (op_wr) begin
                  state <= S_DATA;
                end else begin
                  // Read issues straight from the last address byte for 1-cycle latency.
                  mem.mem_valid_o <= 1'b1;
                  mem.mem_addr_o  <= {addr[23:0], rx_data[7:2], 2'b00};
                  mem.mem_wdata_o <= wdata;
                  mem.mem_wstrb_o <= 4'h0;
                  bus_cnt         <= '0;
                  state           <= S_BUS;
                end
              end
            end else if (state == S_DATA) begin
              wdata <= {wdata[23:0], rx_data};
              if (byte_cnt == 2'd3) state <= S_STRB;
            end else begin
              mem.mem_valid_o <= 1'b1;
              mem.mem_addr_o  <= {addr[31:2], 2'b00};
              mem.mem_wdata_o <= wdata;
              mem.mem_wstrb_o <= rx_data[3:0];
              bus_cnt         <= '0;
              state           <= S_BUS;
            end
          end else if (frame_cnt == FW'(FRAME_TIMEOUT - 1)) begin
            state <= S_IDLE;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end

        S_BUS: begin
          if (rx_valid) rx_overrun <= 1'b1;
          // Ready is checked first so a completion on the final cycle still counts.
          if (mem.mem_ready_i) begin
            mem.mem_valid_o <= 1'b0;
            tx_valid        <= 1'b1;
            state           <= S_RESP;
            if (op_wr) begin
              tx_data   <= RSP_OK;
              resp_left <= 2'd0;
            end else begin
              tx_data   <= mem.mem_rdata_i[31:24];
              resp_sh   <= mem.mem_rdata_i[23:0];
              resp_left <= 2'd3;
            end
          end else if (bus_cnt == BW'(BUS_TIMEOUT - 1)) begin
            mem.mem_valid_o <= 1'b0;
            tx_valid        <= 1'b1;
            tx_data         <= RSP_TO;
            resp_left       <= 2'd0;
            state           <= S_RESP;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (tx_ready) begin
            if (resp_left == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data   <= resp_sh[23:16];
              resp_sh   <= {resp_sh[15:0], 8'h00};
              resp_left <= resp_left - 2'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench: table of read/write transactions plus hand sequences for
// frame timeout, back-pressure/overrun, idle ready and reset mid-transaction.
`timescale 1ns/1ps
module tb_uart_bus_master;
  localparam int BT = 16;
  localparam int FT = 40;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_overrun;

  uart_bus_master_if mem_if ();

  uart_bus_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .mem        (mem_if.master),
    .busy       (busy),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  strb;
    int          wait_n;
    bit          no_ready;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_cycles;
    int          exp_n;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t       vecs [7];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] got [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; the byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(v.wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(v.addr[8*i +: 8]);
    if (v.wr) begin
      for (int i = 3; i >= 0; i--) send_byte(v.wdata[8*i +: 8]);
      send_byte(v.strb);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int stall_at,
                         input int stall_len, input bit inject);
    logic [31:0] a0, d0, gw;
    logic [3:0]  w0;
    logic [7:0]  held;
    bit          stable, tx_stable;
    int          cyc, stl, ovr;
    send_frame(v);
    chk({tag, ".latency"}, {31'd0, mem_if.mem_valid_o}, 32'd1);
    a0 = mem_if.mem_addr_o; w0 = mem_if.mem_wstrb_o; d0 = mem_if.mem_wdata_o;
    stable = 1'b1; cyc = 0;
    while (mem_if.mem_valid_o && cyc < 100) begin
      if (mem_if.mem_addr_o !== a0 || mem_if.mem_wstrb_o !== w0 || mem_if.mem_wdata_o !== d0)
        stable = 1'b0;
      if (!v.no_ready && cyc == v.wait_n) begin
        mem_if.mem_ready_i = 1'b1;
        mem_if.mem_rdata_i = v.rdata;
      end
      tick();
      mem_if.mem_ready_i = 1'b0;
      mem_if.mem_rdata_i = 32'h0;
      cyc++;
    end
    chk({tag, ".addr"}, a0, v.exp_addr);
    chk({tag, ".wstrb"}, {28'd0, w0}, {28'd0, v.exp_wstrb});
    if (v.wr) chk({tag, ".wdata"}, d0, v.wdata);
    chk({tag, ".bus_stable"}, {31'd0, stable}, 32'd1);
    chk({tag, ".valid_cycles"}, cyc, v.exp_cycles);

    got.delete(); cyc = 0; stl = 0; ovr = 0; tx_stable = 1'b1; held = 8'h00;
    while (cyc < 200) begin
      if (!tx_valid && got.size() > 0) break;
      if (got.size() == stall_at && stl < stall_len) begin
        tx_ready = 1'b0;
        if (stl > 0 && tx_data !== held) tx_stable = 1'b0;
        held = tx_data;
        stl++;
      end else begin
        tx_ready = 1'b1;
      end
      if (inject && cyc == 2) begin rx_data = 8'h52; rx_valid = 1'b1; end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      if (rx_overrun) ovr++;
      cyc++;
    end
    gw = 32'h0;
    foreach (got[i]) gw = {gw[23:0], got[i]};
    chk({tag, ".tx_count"}, got.size(), v.exp_n);
    chk({tag, ".tx_bytes"}, gw, v.exp_tx);
    chk({tag, ".overrun_pulses"}, ovr, inject ? 32'd1 : 32'd0);
    if (stall_len > 0) chk({tag, ".tx_stall_stable"}, {31'd0, tx_stable}, 32'd1);
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    //        wr addr          wdata         strb  wait nr rdata         exp_addr      ws    cyc n  exp_tx
    vecs[0] = '{0, 32'h00000010, 32'h0,        8'h00, 3,  0, 32'hDEADBEEF, 32'h00000010, 4'h0, 4,  4, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h10000000, 32'h12345678, 8'h03, 0,  0, 32'h0,        32'h10000000, 4'h3, 1,  1, 32'h0000004B};
    vecs[2] = '{0, 32'h20000000, 32'h0,        8'h00, 0,  1, 32'h0,        32'h20000000, 4'h0, BT, 1, 32'h00000054};
    vecs[3] = '{0, 32'h00001237, 32'h0,        8'h00, 0,  0, 32'h01020304, 32'h00001234, 4'h0, 1,  4, 32'h01020304};
    vecs[4] = '{1, 32'hA5A5A5A6, 32'hCAFEF00D, 8'hFC, 1,  0, 32'h0,        32'hA5A5A5A4, 4'hC, 2,  1, 32'h0000004B};
    vecs[5] = '{1, 32'h30000000, 32'h11223344, 8'h0F, 0,  1, 32'h0,        32'h30000000, 4'hF, BT, 1, 32'h00000054};
    vecs[6] = '{0, 32'h00000100, 32'h0,        8'h00, BT-1, 0, 32'h55AA0FF0, 32'h00000100, 4'h0, BT, 4, 32'h55AA0FF0};

    resetn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    mem_if.mem_ready_i = 1'b0; mem_if.mem_rdata_i = 32'h0;
    repeat (3) tick();
    chk("rst.mem_valid", {31'd0, mem_if.mem_valid_o}, 32'd0);
    chk("rst.mem_addr", mem_if.mem_addr_o, 32'd0);
    chk("rst.mem_wdata", mem_if.mem_wdata_o, 32'd0);
    chk("rst.mem_wstrb", {28'd0, mem_if.mem_wstrb_o}, 32'd0);
    chk("rst.tx", {23'd0, tx_valid, tx_data}, 32'd0);
    chk("rst.busy_ovr", {30'd0, busy, rx_overrun}, 32'd0);
    resetn = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i), -1, 0, 1'b0);

    // Ready while no request is outstanding must be ignored.
    mem_if.mem_ready_i = 1'b1;
    repeat (3) tick();
    mem_if.mem_ready_i = 1'b0;
    chk("idle_ready.state", {29'd0, busy, tx_valid, mem_if.mem_valid_o}, 32'd0);

    // Garbage byte, then a truncated frame that must time out.
    send_byte(8'h41);
    chk("garbage.busy", {31'd0, busy}, 32'd0);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    begin
      bit seen;
      seen = 1'b0;
      repeat (FT - 1) begin
        tick();
        if (mem_if.mem_valid_o || tx_valid) seen = 1'b1;
      end
      chk("ftmo.busy_before", {31'd0, busy}, 32'd1);
      tick();
      chk("ftmo.busy_after", {31'd0, busy}, 32'd0);
      chk("ftmo.no_activity", {31'd0, seen}, 32'd0);
    end
    run_vec(vecs[0], "after_ftmo", -1, 0, 1'b0);

    // Response stalled 10 cycles after the first byte, with a byte injected in RESP.
    run_vec(vecs[0], "backpressure", 1, 10, 1'b1);

    // Reset asserted while the bus request is outstanding.
    send_frame(vecs[2]);
    repeat (3) tick();
    chk("rstbus.pre_valid", {31'd0, mem_if.mem_valid_o}, 32'd1);
    resetn = 1'b0;
    tick();
    chk("rstbus.post", {29'd0, mem_if.mem_valid_o, tx_valid, busy}, 32'd0);
    resetn = 1'b1;
    tick();
    run_vec(vecs[1], "after_rst", -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
